// File: rtl/ro_meas_sched.sv
// ro_meas_sched: ring-oscillator measurement sequencer with serial result drain
module ro_meas_sched #(
    parameter int NUM_RO = 25,
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 24,
    parameter int SEL_W  = 5
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic [7:0]       cfg_settle,
    input  logic [15:0]      cfg_num_samples,
    input  logic             cfg_trig_en,
    input  logic             start,
    input  logic             stop,
    input  logic             ext_trig,
    output logic             ro_en,
    output logic             cnt_clr,
    output logic             cnt_latch,
    output logic [SEL_W-1:0] ro_sel,
    input  logic [CNT_W-1:0] cnt_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic [SEL_W-1:0] res_idx,
    output logic             res_last,
    output logic             busy,
    output logic             done,
    output logic [15:0]      sample_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SETTLE, S_MEASURE, S_LATCH, S_FETCH, S_PRESENT, S_DONE
    } state_t;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_RO - 1);
    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d, timer_q, timer_d, win_m1;
    logic [7:0]         settle_q, settle_d;
    logic [15:0]        nsamp_q, nsamp_d, sample_cnt_q, sample_cnt_d, sample_inc;
    logic               stop_pend_q, stop_pend_d;
    logic [SEL_W-1:0]   ro_sel_q, ro_sel_d, res_idx_q, res_idx_d;
    logic [CNT_W-1:0]   res_data_q, res_data_d;
    logic               res_valid_q, res_valid_d, res_last_q, res_last_d;
    logic [2:0]         trig_q;
    logic               go, hs, finish;
    assign win_m1     = (win_q == '0) ? '0 : win_q - WIN_W'(1);
    assign sample_inc = sample_cnt_q + 16'd1;
    assign go         = cfg_trig_en ? (trig_q[1] & ~trig_q[2]) : start;
    assign hs         = res_valid_q & res_ready;
    assign finish     = stop_pend_q | stop | (nsamp_q != '0 && sample_inc == nsamp_q);
    assign ro_en      = state_q inside {S_CLEAR, S_SETTLE, S_MEASURE};
    assign cnt_clr    = state_q == S_CLEAR;
    assign cnt_latch  = state_q == S_LATCH;
    assign busy       = state_q != S_IDLE;
    assign done       = state_q == S_DONE;
    assign ro_sel     = ro_sel_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_idx    = res_idx_q;
    assign res_last   = res_last_q;
    assign sample_cnt = sample_cnt_q;
    // State, captured config, drain registers and the trigger synchronizer/edge history
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= S_IDLE;
            win_q        <= '0;
            settle_q     <= '0;
            nsamp_q      <= '0;
            sample_cnt_q <= '0;
            stop_pend_q  <= 1'b0;
            timer_q      <= '0;
            ro_sel_q     <= '0;
            res_idx_q    <= '0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            res_last_q   <= 1'b0;
            trig_q       <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            settle_q     <= settle_d;
            nsamp_q      <= nsamp_d;
            sample_cnt_q <= sample_cnt_d;
            stop_pend_q  <= stop_pend_d;
            timer_q      <= timer_d;
            ro_sel_q     <= ro_sel_d;
            res_idx_q    <= res_idx_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            res_last_q   <= res_last_d;
            trig_q       <= {trig_q[1:0], ext_trig};
        end
    end
    // Sequencing: clear, settle, measure, latch, then fetch/present each RO count in turn
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        settle_d     = settle_q;
        nsamp_d      = nsamp_q;
        sample_cnt_d = sample_cnt_q;
        stop_pend_d  = stop_pend_q | (stop & busy);
        timer_d      = timer_q;
        ro_sel_d     = ro_sel_q;
        res_idx_d    = res_idx_q;
        res_data_d   = res_data_q;
        res_valid_d  = res_valid_q;
        res_last_d   = res_last_q;
        case (state_q)
            S_IDLE: if (go) begin
                state_d      = S_CLEAR;
                win_d        = cfg_window;
                settle_d     = cfg_settle;
                nsamp_d      = cfg_num_samples;
                sample_cnt_d = '0;
            end
            S_CLEAR: begin
                state_d = (settle_q == '0) ? S_MEASURE : S_SETTLE;
                timer_d = (settle_q == '0) ? win_m1 : WIN_W'(settle_q) - WIN_W'(1);
            end
            S_SETTLE: begin
                state_d = (timer_q == '0) ? S_MEASURE : S_SETTLE;
                timer_d = (timer_q == '0) ? win_m1 : timer_q - WIN_W'(1);
            end
            S_MEASURE: if (timer_q == '0) begin
                state_d  = S_LATCH;
                ro_sel_d = '0;
            end else begin
                timer_d = timer_q - WIN_W'(1);
            end
            S_LATCH: state_d = S_FETCH;
            S_FETCH: begin
                state_d     = S_PRESENT;
                res_data_d  = cnt_data;
                res_idx_d   = ro_sel_q;
                res_last_d  = ro_sel_q == LAST_SEL;
                res_valid_d = 1'b1;
            end
            S_PRESENT: if (hs) begin
                res_valid_d = 1'b0;
                if (!res_last_q) begin
                    ro_sel_d = ro_sel_q + SEL_W'(1);
                    state_d  = S_FETCH;
                end else begin
                    sample_cnt_d = sample_inc;
                    state_d      = finish ? S_DONE : S_CLEAR;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                stop_pend_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ro_meas_sched.sv
// tb_ro_meas_sched: table-driven checks of run timing, drain order, stop, trigger and reset
module tb_ro_meas_sched;
    logic        ACLK, ARESETN;
    logic [23:0] cfg_window;
    logic [7:0]  cfg_settle;
    logic [15:0] cfg_num_samples;
    logic        cfg_trig_en, start, stop, ext_trig;
    logic        ro_en, cnt_clr, cnt_latch;
    logic [4:0]  ro_sel, res_idx;
    logic [31:0] cnt_data, res_data;
    logic        res_valid, res_ready, res_last, busy, done;
    logic [15:0] sample_cnt;
    int total = 0;
    int bad = 0;
    int row = 0;

    typedef struct {
        int settle, win, ns, bp_idx, stop_cyc, trig;
        int e_done, e_clr, e_res, e_en, e_scnt;
    } rec_t;
    rec_t tbl[8];

    ro_meas_sched dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .cfg_window(cfg_window), .cfg_settle(cfg_settle),
        .cfg_num_samples(cfg_num_samples), .cfg_trig_en(cfg_trig_en), .start(start),
        .stop(stop), .ext_trig(ext_trig), .ro_en(ro_en), .cnt_clr(cnt_clr),
        .cnt_latch(cnt_latch), .ro_sel(ro_sel), .cnt_data(cnt_data), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
        .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    assign cnt_data = {16'hBEEF, 11'd0, ro_sel};

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [31:0] model(input int idx);
        return {16'hBEEF, 11'd0, 5'(idx)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL row%0d %s: got %0d expected %0d", row, name, act, exp);
        end
    endtask

    task automatic kick(input rec_t r);
        int lat;
        cfg_settle      = 8'(r.settle);
        cfg_window      = 24'(r.win);
        cfg_num_samples = 16'(r.ns);
        cfg_trig_en     = r.trig != 0;
        res_ready       = 1'b1;
        if (r.trig != 0) begin
            ext_trig = 1'b0;
            @(negedge ACLK); start = 1'b1;
            @(negedge ACLK); start = 1'b0;
            @(negedge ACLK);
            chk("start_ignored", busy, 0);
            @(posedge ACLK); #2 ext_trig = 1'b1;
            lat = 0;
            while (!busy && lat < 10) begin
                @(posedge ACLK); #1 lat++;
            end
            chk("trig_latency", lat, 3);
            @(negedge ACLK);
        end else begin
            @(negedge ACLK); start = 1'b1;
            @(negedge ACLK); start = 1'b0;
        end
    endtask

    task automatic run(input rec_t r);
        int cyc = 0, n_clr = 0, n_lat = 0, n_en = 0, n_res = 0, oerr = 0;
        int stall = 0, d_cyc = -1, eidx = 0;
        logic [15:0] scnt = '0;
        bit seen = 0, bp_done = 0;
        kick(r);
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (busy) cyc++;
            if (cyc == 2) begin
                cfg_window = 24'd7; cfg_settle = 8'd9; cfg_num_samples = 16'd1;
            end
            stop = (cyc == r.stop_cyc);
            if (r.trig != 0) begin
                ext_trig = !(cyc >= 20 && cyc < 30);
                start    = (cyc == 40);
            end
            if (cnt_clr) n_clr++;
            if (cnt_latch) n_lat++;
            if (ro_en) n_en++;
            if (stall > 0) begin
                stall--;
                res_ready = (stall == 0);
                if (!res_valid || res_idx !== 5'd3 || res_data !== model(3)) oerr++;
            end else if (res_valid && int'(res_idx) == r.bp_idx && !bp_done) begin
                bp_done = 1; stall = 5; res_ready = 1'b0;
            end
            if (res_valid && ro_en) oerr++;
            if (res_valid && res_ready) begin
                if (int'(res_idx) != eidx || res_last !== (eidx == 24) || res_data !== model(eidx)) oerr++;
                eidx = (eidx == 24) ? 0 : eidx + 1;
                n_res++;
            end
            if (done) begin
                seen = 1; d_cyc = cyc; scnt = sample_cnt;
            end else begin
                @(negedge ACLK);
            end
        end
        stop = 1'b0; start = 1'b0; res_ready = 1'b1;
        chk("done_seen", seen, 1);
        chk("done_cycle", d_cyc, r.e_done);
        chk("clr_pulses", n_clr, r.e_clr);
        chk("latch_pulses", n_lat, r.e_clr);
        chk("ro_en_cycles", n_en, r.e_en);
        chk("results", n_res, r.e_res);
        chk("order_errors", oerr, 0);
        chk("sample_cnt", scnt, r.e_scnt);
        @(negedge ACLK);
        chk("idle_after", {busy, done}, 0);
        if (r.trig != 0) begin
            repeat (6) @(negedge ACLK);
            chk("no_retrigger", busy, 0);
        end
    endtask

    initial begin
        bit found;
        tbl[0] = '{0, 10, 1, -1, -1,  0,  63, 1, 25, 11, 1};
        tbl[1] = '{4,  3, 3, -1, -1,  0, 178, 3, 75, 24, 3};
        tbl[2] = '{0,  0, 1, -1, -1,  0,  54, 1, 25,  2, 1};
        tbl[3] = '{0,  2, 1,  3, -1,  0,  60, 1, 25,  3, 1};
        tbl[4] = '{0, 10, 0, -1, 68,  0, 125, 2, 50, 22, 2};
        tbl[5] = '{0, 10, 0, -1, 123, 0, 125, 2, 50, 22, 2};
        tbl[6] = '{0, 10, 1, -1, -1,  1,  63, 1, 25, 11, 1};
        tbl[7] = '{2,  1, 2, -1, -1,  0, 111, 2, 50,  8, 2};
        ARESETN = 1'b0; cfg_window = '0; cfg_settle = '0; cfg_num_samples = '0;
        cfg_trig_en = 1'b0; start = 1'b0; stop = 1'b0; ext_trig = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("reset_ctrl", {busy, ro_en, cnt_clr, cnt_latch, res_valid, res_last, done, ro_sel, res_idx, sample_cnt}, 0);
        chk("reset_data", res_data, 0);
        @(negedge ACLK); ARESETN = 1'b1;
        for (int i = 0; i < 7; i++) begin
            row = i;
            run(tbl[i]);
        end
        row = 7;
        @(negedge ACLK); stop = 1'b1;
        @(negedge ACLK); stop = 1'b0;
        run(tbl[7]);
        row = 8;
        kick(tbl[3]);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (res_valid && res_idx == 5'd10) found = 1;
            else @(negedge ACLK);
        end
        chk("reach_idx10", found, 1);
        #1 ARESETN = 1'b0;
        #1 chk("midrun_reset_ctrl", {busy, ro_en, cnt_clr, cnt_latch, res_valid, res_last, done, ro_sel, res_idx, sample_cnt}, 0);
        chk("midrun_reset_data", res_data, 0);
        @(negedge ACLK); ARESETN = 1'b1;
        row = 9;
        run(tbl[0]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
